// File: rtl/fifo_senior_if.sv
// Port bundle for fifo_senior. It carries the write/read requests, the read data, the occupancy and status flags, and the sticky error flags.
// The slave modport is the FIFO side. The master modport is the producer/consumer side.
interface fifo_senior_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              write_i;
    logic [DATA_W-1:0] data_i;
    logic              read_i;
    logic              clr_err_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              full_o;
    logic              empty_o;
    logic              almost_full_o;
    logic              almost_empty_o;
    logic [CNT_W-1:0]  count_o;
    logic              overflow_o;
    logic              underflow_o;

    modport slave (
        input  write_i, data_i, read_i, clr_err_i,
        output data_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );

    modport master (
        output write_i, data_i, read_i, clr_err_i,
        input  data_o, valid_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/fifo_senior.sv
// Single-clock elastic FIFO. Read latency is one cycle (FWFT=0), or the head is shown combinationally (FWFT=1).
// A write is refused when the FIFO is full unless a pop happens in the same cycle. A read is refused when it is empty. Both refusals set sticky flags.
module fifo_senior #(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AFULL_LVL  = 14,
    parameter int AEMPTY_LVL = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fifo_senior_if.slave bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AFULL_LVL);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AEMPTY_LVL);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full, empty;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] head_dat;

    // The flags come only from the registered count, so no input reaches a status output combinationally.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        rd_acc      = bus.read_i && !empty;
        wr_acc      = bus.write_i && (!full || rd_acc);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q && !bus.clr_err_i;
        underflow_d = underflow_q && !bus.clr_err_i;

        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A new error in the same cycle as a clear leaves the flag set.
        if (bus.write_i && !wr_acc) overflow_d  = 1'b1;
        if (bus.read_i  && !rd_acc) underflow_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // The storage array has no reset. A slot is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.data_i;
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.data_o  = head_dat;
        assign bus.valid_o = !empty;
    end else begin : g_reg
        logic [DATA_W-1:0] rd_dat_q, rd_dat_d;
        logic              rd_vld_q, rd_vld_d;

        always_comb begin
            rd_vld_d = rd_acc;
            rd_dat_d = rd_dat_q;
            if (rd_acc) rd_dat_d = head_dat;
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_dat_q <= '0;
                rd_vld_q <= 1'b0;
            end else begin
                rd_dat_q <= rd_dat_d;
                rd_vld_q <= rd_vld_d;
            end
        end

        assign bus.data_o  = rd_dat_q;
        assign bus.valid_o = rd_vld_q;
    end

    assign bus.full_o         = full;
    assign bus.empty_o        = empty;
    assign bus.almost_full_o  = (count_q >= CNT_AF);
    assign bus.almost_empty_o = (count_q <= CNT_AE);
    assign bus.count_o        = count_q;
    assign bus.overflow_o     = overflow_q;
    assign bus.underflow_o    = underflow_q;
endmodule

// File: doc/fifo_senior.md
Name: fifo_senior

Overview:
- Synchronous single-clock FIFO; parametrised successor to the team's fixed-size 16x8 FIFO.
- Generalised in data width and depth (power of two).
- Selectable read mode: registered or first-word fall-through.
- Adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and pass-through read+write when full.
- Sits between producer/consumer blocks in the datapath as the standard elastic buffer.

Parameters:
DATA_W, 8, data bus width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
FWFT, 0, 0 = registered read (1-cycle latency), 1 = first-word fall-through
AFULL_LVL, 14, almost_full_o asserted when count_o >= AFULL_LVL (1..DEPTH)
AEMPTY_LVL, 2, almost_empty_o asserted when count_o <= AEMPTY_LVL (0..DEPTH-1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
write_i  in  1  write request
data_i  in  DATA_W  write data
read_i  in  1  read/pop request
data_o  out  DATA_W  read data
valid_o  out  1  data_o holds valid read data
full_o  out  1  count_o == DEPTH
empty_o  out  1  count_o == 0
almost_full_o  out  1  count_o >= AFULL_LVL
almost_empty_o  out  1  count_o <= AEMPTY_LVL
count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow_o  out  1  sticky: write rejected
underflow_o  out  1  sticky: read rejected
clr_err_i  in  1  synchronous clear of overflow_o/underflow_o

Behaviour:
- Reset (rst_i=1, async), values held while rst_i high:
  - wr_ptr, rd_ptr, count_o = 0.
  - data_o = 0, valid_o = 0 (FWFT=0).
  - overflow_o = 0, underflow_o = 0.
  - Memory array is not reset; contents are don't-care.
- Pointers: $clog2(DEPTH) bits; wrap naturally DEPTH-1 -> 0.
- Status outputs: full_o, empty_o, almost_full_o, almost_empty_o are decoded combinationally from the registered count only, never from inputs.
- Acceptance, evaluated per cycle on pre-edge state:
  - rd_acc = read_i && !empty_o.
  - wr_acc = write_i && (!full_o || rd_acc).
  - Write while full is accepted only if a pop happens in the same cycle.
  - Read while empty is always rejected, even with a simultaneous write.
- Update on clock edge:
  - wr_acc: mem[wr_ptr] <= data_i; wr_ptr +1.
  - rd_acc: rd_ptr +1.
  - count_o: +1 if wr_acc only; -1 if rd_acc only; unchanged if both or neither.
- FWFT=0 (registered read):
  - On rd_acc, data_o <= mem[rd_ptr] and valid_o <= 1 at the next edge, i.e. 1-cycle latency.
  - Otherwise valid_o <= 0 and data_o holds its last value.
- FWFT=1 (fall-through):
  - data_o = mem[rd_ptr] combinationally; valid_o = !empty_o.
  - A written word appears on data_o the cycle after the write edge.
  - read_i acts as acknowledge of the current head.
- Errors:
  - write_i && !wr_acc sets overflow_o.
  - read_i && !rd_acc sets underflow_o.
  - Both are sticky until the edge where clr_err_i=1.
  - If clr_err_i and a new error occur in the same cycle, set wins.
- Rejected operations change no pointer, count, or memory content.

Test Plan:
- Reset, then idle -> count_o=0, empty_o=1, almost_empty_o=1, full_o=0, valid_o=0, data_o=0, error flags 0.
- FWFT=0: write 0xA5, 0x3C on consecutive cycles, then read twice -> data_o=0xA5 with valid_o=1 one cycle after the first read, then 0x3C; count_o goes 1,2,1,0; empty_o=1 at end.
- Fill 16 words 0x00..0x0F, attempt a 17th write of 0xFF -> almost_full_o=1 at count 14; full_o=1 at 16; overflow_o=1; count_o stays 16; draining yields 0x00..0x0F in order (verifies wrap).
- Full, read_i=1 and write_i=1 with 0x77 same cycle -> both accepted, count_o stays 16, no overflow; 0x77 is the last word drained.
- Empty, read_i=1 and write_i=1 with 0x12 -> read rejected, underflow_o=1, count_o=1; later clr_err_i=1 -> underflow_o=0 next cycle.
- FWFT=1: write 0x5A -> next cycle data_o=0x5A, valid_o=1 without read; read_i=1 -> empty_o=1, valid_o=0. Assert rst_i mid-stream with count 5 -> outputs return to reset values immediately, without waiting for a clock edge.
